// File: rtl/instr_aligner_if.sv
// instr_aligner_if: bus bundle between the instruction FIFO, the aligner and the decoder.
// When INSTR_ALIGNER_PERF_EN is defined, the bundle also carries the two perf counters.
interface instr_aligner_if #(
    parameter int unsigned WORD_LEN = 32,
    parameter int unsigned FIFO_W   = 16,
    parameter int unsigned BUF_W    = 32,
    parameter int unsigned MAX_LEN  = 4
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned OCC_W = $clog2(BUF_W + 1);

    logic                             flush;
    logic [0:FIFO_W-1][0:WORD_LEN-1]  in_data;
    logic                             in_vld;
    logic                             in_rdy;
    logic [0:MAX_LEN-1][0:WORD_LEN-1] out_data;
    logic [LEN_W-1:0]                 out_len;
    logic                             out_vld;
    logic                             out_rdy;
    logic                             err;
    logic [OCC_W-1:0]                 occupancy;

`ifdef INSTR_ALIGNER_PERF_EN
    logic [31:0]                      perf_instr_cnt;
    logic [31:0]                      perf_starve_cnt;

    modport master (
        output flush, in_data, in_vld, out_rdy,
        input  in_rdy, out_data, out_len, out_vld, err, occupancy,
        input  perf_instr_cnt, perf_starve_cnt
    );

    modport slave (
        input  flush, in_data, in_vld, out_rdy,
        output in_rdy, out_data, out_len, out_vld, err, occupancy,
        output perf_instr_cnt, perf_starve_cnt
    );
`else
    modport master (
        output flush, in_data, in_vld, out_rdy,
        input  in_rdy, out_data, out_len, out_vld, err, occupancy
    );

    modport slave (
        input  flush, in_data, in_vld, out_rdy,
        output in_rdy, out_data, out_len, out_vld, err, occupancy
    );
`endif
endinterface

// File: rtl/instr_aligner.sv
// instr_aligner: realigns fixed-width FIFO beats into whole variable-length instructions,
// presented left-aligned at word 0, one per cycle. Length comes from LEN_TABLE indexed by
// the leading LEN_CODE_W bits of the head word; a zero entry marks an illegal code (sticky err).
// Optional feature macro: INSTR_ALIGNER_PERF_EN adds perf_instr_cnt / perf_starve_cnt.
module instr_aligner #(
    parameter int unsigned WORD_LEN   = 32,
    parameter int unsigned FIFO_W     = 16,
    parameter int unsigned BUF_W      = 32,
    parameter int unsigned LEN_CODE_W = 2,
    parameter logic [0:(1<<LEN_CODE_W)-1][7:0] LEN_TABLE = {8'd1, 8'd2, 8'd4, 8'd0}
) (
    input  logic           clk,
    input  logic           rst,
    instr_aligner_if.slave bus
);
    localparam int unsigned N_CODES = 1 << LEN_CODE_W;

    // Largest instruction length in the table; sizes the output window.
    function automatic int unsigned max_len_f(input logic [0:N_CODES-1][7:0] tbl);
        int unsigned m;
        m = 0;
        for (int i = 0; i < int'(N_CODES); i++) begin
            if (32'(tbl[LEN_CODE_W'(i)]) > m) m = 32'(tbl[LEN_CODE_W'(i)]);
        end
        return m;
    endfunction

    localparam int unsigned MAX_LEN = max_len_f(LEN_TABLE);
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned CNT_W   = $clog2(BUF_W + 1);
    localparam int unsigned IDX_W   = (BUF_W > 1) ? $clog2(BUF_W) : 1;
    localparam int unsigned FIDX_W  = (FIFO_W > 1) ? $clog2(FIFO_W) : 1;
    localparam int unsigned OIDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Reject parameter sets that cannot hold or present a full instruction.
    if (MAX_LEN > FIFO_W || MAX_LEN == 0 || BUF_W < FIFO_W) begin : g_param_check
        $fatal(1, "instr_aligner: need 0 < MAX_LEN <= FIFO_W <= BUF_W");
    end

    typedef logic [0:WORD_LEN-1] word_t;

    word_t                 buf_q [BUF_W];
    word_t                 buf_d [BUF_W];
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  err_q;
    logic                  err_d;

    logic [LEN_CODE_W-1:0] head_code;
    logic [LEN_W-1:0]      head_len;
    logic                  do_pop;
    logic                  do_push;

    // Length lookup for the instruction starting at word 0.
    always_comb begin
        head_code = buf_q[0][0:LEN_CODE_W-1];
        head_len  = LEN_W'(LEN_TABLE[head_code]);
    end

    // Output window and handshake qualifiers; flush gates both directions in the same cycle.
    always_comb begin
        bus.in_rdy    = !bus.flush && (32'(cnt_q) <= BUF_W - FIFO_W);
        bus.out_vld   = !bus.flush && !err_q && (head_len != '0) && (32'(cnt_q) >= 32'(head_len));
        bus.out_len   = head_len;
        bus.err       = err_q;
        bus.occupancy = cnt_q;
        bus.out_data  = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            bus.out_data[OIDX_W'(i)] = buf_q[IDX_W'(i)];
        end
    end

    // Completed transfers this cycle.
    always_comb begin
        do_pop  = bus.out_vld && bus.out_rdy;
        do_push = bus.in_vld && bus.in_rdy;
    end

    // Next buffer: drop the popped instruction, then append the beat behind the survivors.
    always_comb begin
        int unsigned base;
        int unsigned src;
        int unsigned cnt_n;
        base  = 32'(cnt_q);
        src   = 0;
        cnt_n = 32'(cnt_q);
        for (int i = 0; i < int'(BUF_W); i++) begin
            buf_d[IDX_W'(i)] = buf_q[IDX_W'(i)];
        end
        if (do_pop) begin
            base  = base - 32'(head_len);
            cnt_n = cnt_n - 32'(head_len);
            for (int i = 0; i < int'(BUF_W); i++) begin
                src = 32'(i) + 32'(head_len);
                buf_d[IDX_W'(i)] = (src < BUF_W) ? buf_q[IDX_W'(src)] : '0;
            end
        end
        if (do_push) begin
            for (int k = 0; k < int'(FIFO_W); k++) begin
                if (base + 32'(k) < BUF_W) begin
                    buf_d[IDX_W'(base + 32'(k))] = bus.in_data[FIDX_W'(k)];
                end
            end
            cnt_n = cnt_n + FIFO_W;
        end
        cnt_d = CNT_W'(cnt_n);
        err_d = err_q || ((cnt_q != '0) && (head_len == '0));
        if (bus.flush) begin
            for (int i = 0; i < int'(BUF_W); i++) begin
                buf_d[IDX_W'(i)] = '0;
            end
            cnt_d = '0;
            err_d = 1'b0;
        end
    end

    // Buffer, fill level and sticky error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_W); i++) begin
                buf_q[IDX_W'(i)] <= '0;
            end
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Fill level must stay within 0..BUF_W.
    always @(posedge clk) begin
        if (!rst) begin
            assert (32'(cnt_q) <= BUF_W)
                else $error("instr_aligner: cnt overflow");
            assert (!(do_pop && (32'(cnt_q) < 32'(head_len))))
                else $error("instr_aligner: cnt underflow");
        end
    end

`ifdef INSTR_ALIGNER_PERF_EN
    logic [31:0] perf_instr_q;
    logic [31:0] perf_instr_d;
    logic [31:0] perf_starve_q;
    logic [31:0] perf_starve_d;

    // Count delivered instructions and cycles where the decoder waited on us.
    always_comb begin
        perf_instr_d  = perf_instr_q + (do_pop ? 32'd1 : 32'd0);
        perf_starve_d = perf_starve_q
                      + ((bus.out_rdy && !bus.out_vld && !bus.flush) ? 32'd1 : 32'd0);
        bus.perf_instr_cnt  = perf_instr_q;
        bus.perf_starve_cnt = perf_starve_q;
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_instr_q  <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_instr_q  <= perf_instr_d;
            perf_starve_q <= perf_starve_d;
        end
    end
`else
    // No performance counters in this build.
`endif
endmodule

// File: tb/tb_instr_aligner.sv
// tb_instr_aligner: vector table, hand-written corner sequences and random traffic,
// all checked against a word-queue reference model of the aligner.
module tb_instr_aligner;
    localparam int unsigned WORD_LEN = 32;
    localparam int unsigned FIFO_W   = 4;
    localparam int unsigned BUF_W    = 8;
    localparam int unsigned MAX_LEN  = 4;
    localparam int          NV       = 19;

    typedef logic [0:WORD_LEN-1]              word_t;
    typedef logic [0:FIFO_W-1][0:WORD_LEN-1]  beat_t;
    typedef logic [0:MAX_LEN-1][0:WORD_LEN-1] odata_t;

    typedef struct {
        bit vld;
        int beat;
        bit rdy;
        bit fl;
        bit e_vld;
        int e_len;
        int e_occ;
        bit e_rdy;
        bit e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_aligner_if #(.WORD_LEN(WORD_LEN), .FIFO_W(FIFO_W), .BUF_W(BUF_W), .MAX_LEN(MAX_LEN)) bus ();

    instr_aligner #(
        .WORD_LEN(WORD_LEN), .FIFO_W(FIFO_W), .BUF_W(BUF_W), .LEN_CODE_W(2),
        .LEN_TABLE({8'd1, 8'd2, 8'd4, 8'd0})
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of buffered words, sticky error, event counters.
    word_t mq[$];
    bit    m_err     = 1'b0;
    int    m_pops    = 0;
    int    m_starve  = 0;

    // Per-cycle values captured at the sample point.
    bit    cur_in_vld, cur_out_rdy, cur_fl, cur_vld, cur_rdy;
    int    cur_len;
    beat_t cur_d;

    beat_t beats[5];
    vec_t  vt[NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t mk(input int code, input int tag);
        word_t w;
        w[0:1]  = 2'(code);
        w[2:31] = 30'(tag);
        return w;
    endfunction

    function automatic int tbl_len(input logic [1:0] code);
        case (code)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic word_t rand_word();
        int c;
        c = int'($urandom_range(0, 15));
        return mk((c == 15) ? 3 : (c % 3), int'($urandom));
    endfunction

    // Apply inputs on the falling edge, then compare every output with the model.
    task automatic drive_sample(input bit vld, input beat_t d, input bit rdy, input bit fl);
        word_t  head;
        odata_t e_od;
        @(negedge clk);
        bus.in_vld  = vld;
        bus.in_data = d;
        bus.out_rdy = rdy;
        bus.flush   = fl;
        #1;
        head    = (mq.size() > 0) ? mq[0] : '0;
        cur_len = tbl_len(head[0:1]);
        cur_rdy = !fl && (mq.size() <= int'(BUF_W - FIFO_W));
        cur_vld = !fl && !m_err && (cur_len != 0) && (mq.size() >= cur_len);
        cur_in_vld  = vld;
        cur_out_rdy = rdy;
        cur_fl      = fl;
        cur_d       = d;
        for (int i = 0; i < int'(MAX_LEN); i++) e_od[i] = (i < mq.size()) ? mq[i] : '0;
        check("in_rdy",    bus.in_rdy,    cur_rdy);
        check("out_vld",   bus.out_vld,   cur_vld);
        check("out_len",   bus.out_len,   cur_len);
        check("occupancy", bus.occupancy, mq.size());
        check("err",       bus.err,       m_err);
        check("out_data",  bus.out_data,  e_od);
`ifdef INSTR_ALIGNER_PERF_EN
        check("perf_instr_cnt",  bus.perf_instr_cnt,  m_pops);
        check("perf_starve_cnt", bus.perf_starve_cnt, m_starve);
`endif
    endtask

    // Clock edge: update the model from what was handshaked this cycle.
    task automatic advance();
        @(posedge clk);
        if (cur_out_rdy && !cur_vld && !cur_fl) m_starve++;
        if (cur_fl) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            if (mq.size() >= 1 && cur_len == 0) m_err = 1'b1;
            if (cur_vld && cur_out_rdy) begin
                repeat (cur_len) void'(mq.pop_front());
                m_pops++;
            end
            if (cur_in_vld && cur_rdy) begin
                for (int i = 0; i < int'(FIFO_W); i++) mq.push_back(cur_d[i]);
            end
        end
    endtask

    task automatic step(input bit vld, input beat_t d, input bit rdy, input bit fl);
        drive_sample(vld, d, rdy, fl);
        advance();
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        check({tag, " occupancy"}, bus.occupancy, 0);
        check({tag, " out_vld"},   bus.out_vld,   0);
        check({tag, " in_rdy"},    bus.in_rdy,    1);
        check({tag, " err"},       bus.err,       0);
        check({tag, " out_len"},   bus.out_len,   1);
        check({tag, " out_data"},  bus.out_data,  0);
        mq.delete();
        m_err    = 1'b0;
        m_pops   = 0;
        m_starve = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        beats[0] = '0;
        beats[1] = {mk(1, 'h11), mk(3, 'h12), mk(0, 'h13), mk(2, 'h14)};
        beats[2] = {mk(3, 'h21), mk(1, 'h22), mk(2, 'h23), mk(0, 'h24)};
        beats[3] = {mk(2, 'h31), mk(3, 'h32), mk(3, 'h33), mk(3, 'h34)};
        beats[4] = {mk(3, 'h41), mk(0, 'h42), mk(0, 'h43), mk(0, 'h44)};

        //          vld beat rdy fl | vld len occ rdy err
        vt[0]  = '{1, 1, 1, 0,  0, 1, 0, 1, 0};
        vt[1]  = '{0, 0, 1, 0,  1, 2, 4, 1, 0};
        vt[2]  = '{1, 2, 1, 0,  1, 1, 2, 1, 0};
        vt[3]  = '{0, 0, 1, 0,  1, 4, 5, 0, 0};
        vt[4]  = '{0, 0, 1, 0,  1, 1, 1, 1, 0};
        vt[5]  = '{0, 0, 1, 0,  0, 1, 0, 1, 0};
        vt[6]  = '{1, 3, 0, 0,  0, 1, 0, 1, 0};
        vt[7]  = '{1, 3, 0, 0,  1, 4, 4, 1, 0};
        vt[8]  = '{1, 3, 1, 0,  1, 4, 8, 0, 0};
        vt[9]  = '{0, 0, 0, 0,  1, 4, 4, 1, 0};
        vt[10] = '{0, 0, 1, 0,  1, 4, 4, 1, 0};
        vt[11] = '{1, 1, 0, 0,  0, 1, 0, 1, 0};
        vt[12] = '{1, 2, 1, 1,  0, 2, 4, 0, 0};
        vt[13] = '{0, 0, 0, 0,  0, 1, 0, 1, 0};
        vt[14] = '{1, 4, 1, 0,  0, 1, 0, 1, 0};
        vt[15] = '{1, 4, 1, 0,  0, 0, 4, 1, 0};
        vt[16] = '{1, 4, 1, 0,  0, 0, 8, 0, 1};
        vt[17] = '{0, 0, 1, 1,  0, 0, 8, 0, 1};
        vt[18] = '{0, 0, 1, 0,  0, 1, 0, 1, 0};

        bus.flush   = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst occupancy", bus.occupancy, 0);
        check("rst in_rdy",    bus.in_rdy,    1);
        check("rst out_vld",   bus.out_vld,   0);
        check("rst err",       bus.err,       0);
        check("rst out_len",   bus.out_len,   1);
        check("rst out_data",  bus.out_data,  0);
        rst = 1'b0;

        // Mixed lengths, full buffer, flush collision, illegal code.
        for (int r = 0; r < NV; r++) begin
            drive_sample(vt[r].vld, beats[vt[r].beat], vt[r].rdy, vt[r].fl);
            check($sformatf("vec%0d out_vld", r),   bus.out_vld,   vt[r].e_vld);
            check($sformatf("vec%0d out_len", r),   bus.out_len,   vt[r].e_len);
            check($sformatf("vec%0d occupancy", r), bus.occupancy, vt[r].e_occ);
            check($sformatf("vec%0d in_rdy", r),    bus.in_rdy,    vt[r].e_rdy);
            check($sformatf("vec%0d err", r),       bus.err,       vt[r].e_err);
            advance();
        end

        // Reset mid-stream with six words buffered.
        step(1'b1, beats[1], 1'b0, 1'b0);
        step(1'b1, beats[2], 1'b1, 1'b0);
        drive_sample(1'b0, beats[0], 1'b0, 1'b0);
        check("midrst pre occupancy", bus.occupancy, 6);
        async_reset("midrst");

        // Randomized traffic with occasional flushes and illegal codes.
        for (int n = 0; n < 600; n++) begin
            beat_t b;
            for (int i = 0; i < int'(FIFO_W); i++) b[i] = rand_word();
            step($urandom_range(0, 3) != 0, b, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end

`ifdef INSTR_ALIGNER_PERF_EN
        // Ten pops and three starved cycles from a clean reset.
        drive_sample(1'b0, beats[0], 1'b0, 1'b0);
        async_reset("perfrst");
        repeat (3) step(1'b0, beats[0], 1'b1, 1'b0);
        for (int b = 0; b < 3; b++) begin
            beat_t ones;
            for (int i = 0; i < int'(FIFO_W); i++) ones[i] = mk(0, 'h50 + 4 * b + i);
            step(1'b1, ones, 1'b0, 1'b0);
            repeat ((b < 2) ? 4 : 2) step(1'b0, beats[0], 1'b1, 1'b0);
        end
        drive_sample(1'b0, beats[0], 1'b0, 1'b0);
        check("perf instr total",  bus.perf_instr_cnt,  10);
        check("perf starve total", bus.perf_starve_cnt, 3);
        advance();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
